alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational 6-bit ALU (operands A, B; 3-bit function select fxn; result X) between two independent requesters.
- Each requester presents an operation over a valid/ready handshake. The block grants round-robin, holds the operands stable on the ALU, captures the result, and returns it with the winner's ID over a valid/ready response channel.
- Sits between the requester logic and the ALU. The ALU itself stays external and is wired to the alu_* ports.

Parameters:
- W, 6, operand/result width.
- FW, 3, function-select width.
- CW, 8, width of completed-operation counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  W  requester 0 operands.
- req0_fxn  in  FW  requester 0 function select.
- req1_valid, req1_ready, req1_a, req1_b, req1_fxn: same as requester 0, for requester 1.
- alu_a, alu_b  out  W  operands driven to the shared ALU.
- alu_fxn  out  FW  function select driven to the ALU.
- alu_x  in  W  ALU result, combinational from alu_a/alu_b/alu_fxn.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_x  out  W  captured result.
- rsp_id  out  1  requester that issued the result.
- busy  out  1  high whenever state != IDLE.
- done_cnt  out  CW  count of completed response handshakes.

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE
  - alu_a, alu_b, alu_fxn, rsp_x = 0
  - rsp_valid, rsp_id, busy = 0
  - done_cnt = 0
  - last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic is combinational from valids and last_grant.
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1.
  - Both valid -> grant the requester != last_grant.
  - reqN_ready is high only for the granted requester, only in IDLE, same cycle as its valid. It never depends on the other requester's ready.
  - On grant: register a/b/fxn into alu_a/alu_b/alu_fxn, set rsp_id and last_grant to the winner, go to EXEC.
  - No valid -> stay IDLE, hold all registers.
- EXEC (exactly 1 cycle):
  - The ALU settles on the stable registered operands.
  - At the end of the cycle, register alu_x into rsp_x and go to RESP.
- RESP:
  - rsp_valid=1. rsp_x and rsp_id stay stable until handshake.
  - On rsp_valid & rsp_ready: clear rsp_valid, increment done_cnt (wraps 2^CW-1 -> 0), go to IDLE.
  - rsp_ready low -> stay in RESP indefinitely. No new grants and no ready to any requester.
- alu_a/alu_b/alu_fxn:
  - Change only on a grant. They hold the last operation in IDLE/RESP, so the ALU output never glitches during EXEC.
- Timing:
  - Latency: accept in cycle N -> rsp_valid high in cycle N+2.
  - Max throughput: one operation per 3 cycles, with rsp_ready held high.
  - Fairness: with both valid continuously, grants alternate 0,1,0,1,...
- Arithmetic:
  - The block does no arithmetic on operands; rsp_x is alu_x verbatim, W bits.
  - done_cnt is modulo 2^CW.
- Requester rules:
  - A requester must hold valid and its a/b/fxn stable until ready.
  - A valid dropped before ready is legal and simply never granted.
- Reset mid-operation (any state):
  - Immediate return to reset values; the in-flight operation is discarded and no response is issued.
  - The round-robin pointer returns to last_grant=1.
- Simultaneous events: none are possible beyond the IDLE tie, because accept and respond happen in different states.

Test Plan:
Bench uses an ALU stub: fxn 000 -> X=A+B mod 64, fxn 001 -> X=A-B mod 64, other codes -> X=A&B.
1. Single request: req0 a=1, b=63, fxn=000, rsp_ready=1 -> req0_ready in cycle N; rsp_valid in cycle N+2 with rsp_x=0, rsp_id=0; done_cnt=1; busy high N+1..N+2.
2. Tie after reset: req0 a=1, b=63, fxn=001 and req1 a=5, b=3, fxn=000, both held valid -> first rsp_x=2, id=0; then rsp_x=8, id=1. req1_ready is never high while busy.
3. Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_x/rsp_id stable, state RESP, both readys low, alu_* unchanged. On rsp_ready=1, exactly one handshake and done_cnt +1.
4. Fairness: both valid for 6 back-to-back ops -> rsp_id sequence 0,1,0,1,0,1; responses spaced 3 cycles apart.
5. Reset in EXEC: grant req1, assert rst the next cycle -> rsp_valid, busy, done_cnt and alu_* read 0 immediately; no response appears. A following tie grants req0 first.
6. Counter wrap: 256 ops with CW=8 -> done_cnt returns to 0 on the 256th handshake.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one external combinational ALU
// between two valid/ready requesters.
// Ports: clk, rst (async, high); req0_*/req1_* request channels
// (valid, ready, a, b, fxn); alu_a/alu_b/alu_fxn to the ALU, alu_x from it;
// rsp_valid/rsp_ready/rsp_x/rsp_id response channel; busy; done_cnt.
module alu_share_arbiter #(
  parameter int W  = 6,
  parameter int FW = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic [FW-1:0] req0_fxn,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  input  logic [FW-1:0] req1_fxn,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [FW-1:0] alu_fxn,
  input  logic [W-1:0]  alu_x,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_x,
  output logic          rsp_id,
  output logic          busy,
  output logic [CW-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [FW-1:0] alu_fxn_q, alu_fxn_d;
  logic [W-1:0]  rsp_x_q, rsp_x_d;
  logic          rsp_id_q, rsp_id_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] done_cnt_q, done_cnt_d;

  logic gnt0, gnt1;

  // On a tie the requester that did not win last time gets the slot.
  assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_fxn_d    = alu_fxn_q;
    rsp_x_d      = rsp_x_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    done_cnt_d   = done_cnt_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 | gnt1) begin
          alu_a_d      = gnt1 ? req1_a : req0_a;
          alu_b_d      = gnt1 ? req1_b : req0_b;
          alu_fxn_d    = gnt1 ? req1_fxn : req0_fxn;
          rsp_id_d     = gnt1;
          last_grant_d = gnt1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_x_d = alu_x;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          done_cnt_d = done_cnt_q + {{(CW-1){1'b0}}, 1'b1};
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_fxn_q    <= '0;
      rsp_x_q      <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_fxn_q    <= alu_fxn_d;
      rsp_x_q      <= rsp_x_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fxn   = alu_fxn_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench for alu_share_arbiter
// with a small ALU stub (add, sub, and).
module tb_alu_share_arbiter;

  localparam int W  = 6;
  localparam int FW = 3;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [W-1:0]  req0_a, req0_b;
  logic [FW-1:0] req0_fxn;
  logic          req1_valid, req1_ready;
  logic [W-1:0]  req1_a, req1_b;
  logic [FW-1:0] req1_fxn;
  logic [W-1:0]  alu_a, alu_b, alu_x;
  logic [FW-1:0] alu_fxn;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_x;
  logic          rsp_id;
  logic          busy;
  logic [CW-1:0] done_cnt;

  int checks = 0;
  int errs   = 0;

  alu_share_arbiter #(.W(W), .FW(FW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_fxn   (req0_fxn),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_fxn   (req1_fxn),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fxn    (alu_fxn),
    .alu_x      (alu_x),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_x      (rsp_x),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  // ALU stub
  always_comb begin
    alu_x = alu_a & alu_b;
    unique case (alu_fxn)
      3'b000:  alu_x = alu_a + alu_b;
      3'b001:  alu_x = alu_a - alu_b;
      default: alu_x = alu_a & alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next response; readies must stay low while busy.
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (!rsp_valid && busy) begin
        chk("rdy0_busy", 32'(req0_ready), 0);
        chk("rdy1_busy", 32'(req1_ready), 0);
      end
    end while (!rsp_valid && n < 20);
    chk("rsp_seen", 32'(rsp_valid), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int n;
  int d0;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_fxn = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_fxn = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done_cnt), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_rsp_x", 32'(rsp_x), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single request, 1 + 63 = 0
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 6'd1; req0_b = 6'd63; req0_fxn = 3'd0;
    rsp_ready = 1'b1;
    #1;
    chk("t1_rdy0", 32'(req0_ready), 1);
    chk("t1_rdy1", 32'(req1_ready), 0);
    chk("t1_busy_n", 32'(busy), 0);
    wait_rsp(n);
    req0_valid = 1'b0;
    chk("t1_lat", n, 2);
    chk("t1_x", 32'(rsp_x), 0);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_busy", 32'(busy), 1);
    @(negedge clk);
    #1;
    chk("t1_done", 32'(done_cnt), 1);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_rv_lo", 32'(rsp_valid), 0);

    // 2: tie after reset, req0 first
    do_reset();
    #1;
    chk("t2_done_rst", 32'(done_cnt), 0);
    req0_valid = 1'b1; req0_a = 6'd1; req0_b = 6'd63; req0_fxn = 3'd1;
    req1_valid = 1'b1; req1_a = 6'd5; req1_b = 6'd3; req1_fxn = 3'd0;
    #1;
    chk("t2_rdy0", 32'(req0_ready), 1);
    chk("t2_rdy1", 32'(req1_ready), 0);
    wait_rsp(n);
    chk("t2_x0", 32'(rsp_x), 2);
    chk("t2_id0", 32'(rsp_id), 0);
    wait_rsp(n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t2_gap", n, 3);
    chk("t2_x1", 32'(rsp_x), 8);
    chk("t2_id1", 32'(rsp_id), 1);
    @(negedge clk);
    #1;
    chk("t2_done", 32'(done_cnt), 2);

    // 3: back-pressure; 10 & 7 = 2
    d0 = 2;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 6'd10; req0_b = 6'd7; req0_fxn = 3'd2;
    req1_valid = 1'b1; req1_a = 6'd3; req1_b = 6'd4; req1_fxn = 3'd0;
    #1;
    chk("t3_rdy0", 32'(req0_ready), 1);
    chk("t3_rdy1", 32'(req1_ready), 0);
    wait_rsp(n);
    req0_valid = 1'b0;
    chk("t3_x", 32'(rsp_x), 2);
    chk("t3_id", 32'(rsp_id), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("t3_hold_rv", 32'(rsp_valid), 1);
      chk("t3_hold_x", 32'(rsp_x), 2);
      chk("t3_hold_id", 32'(rsp_id), 0);
      chk("t3_hold_r1", 32'(req1_ready), 0);
      chk("t3_hold_a", 32'(alu_a), 10);
      chk("t3_hold_b", 32'(alu_b), 7);
      chk("t3_hold_f", 32'(alu_fxn), 2);
      chk("t3_hold_cnt", 32'(done_cnt), d0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_cnt1", 32'(done_cnt), d0 + 1);
    chk("t3_rv_lo", 32'(rsp_valid), 0);
    chk("t3_rdy1_idle", 32'(req1_ready), 1);
    wait_rsp(n);
    req1_valid = 1'b0;
    chk("t3_x1", 32'(rsp_x), 7);
    chk("t3_id1", 32'(rsp_id), 1);
    @(negedge clk);
    #1;
    chk("t3_cnt2", 32'(done_cnt), d0 + 2);

    // 4: fairness, 6 back-to-back ops
    req0_valid = 1'b1; req0_a = 6'd1; req0_b = 6'd2; req0_fxn = 3'd0;
    req1_valid = 1'b1; req1_a = 6'd9; req1_b = 6'd4; req1_fxn = 3'd1;
    for (int i = 0; i < 6; i++) begin
      wait_rsp(n);
      if (i == 5) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      chk("t4_gap", n, (i == 0) ? 2 : 3);
      chk("t4_id", 32'(rsp_id), i % 2);
      chk("t4_x", 32'(rsp_x), (i % 2) ? 5 : 3);
    end
    @(negedge clk);
    #1;
    chk("t4_cnt", 32'(done_cnt), 10);

    // 5: reset during EXEC
    req1_valid = 1'b1; req1_a = 6'd20; req1_b = 6'd30; req1_fxn = 3'd0;
    #1;
    chk("t5_rdy1", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rv", 32'(rsp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_cnt", 32'(done_cnt), 0);
    chk("t5_a", 32'(alu_a), 0);
    chk("t5_b", 32'(alu_b), 0);
    chk("t5_f", 32'(alu_fxn), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("t5_no_rsp", 32'(rsp_valid), 0);
    end
    req0_valid = 1'b1; req0_a = 6'd7; req0_b = 6'd8; req0_fxn = 3'd0;
    req1_valid = 1'b1;
    #1;
    chk("t5_tie_r0", 32'(req0_ready), 1);
    chk("t5_tie_r1", 32'(req1_ready), 0);
    wait_rsp(n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t5_id", 32'(rsp_id), 0);
    chk("t5_x", 32'(rsp_x), 15);

    // 6: counter wrap after 256 handshakes
    do_reset();
    req0_valid = 1'b1; req0_a = 6'd3; req0_b = 6'd5; req0_fxn = 3'd0;
    for (int i = 0; i < 256; i++) begin
      wait_rsp(n);
      if (i == 255) req0_valid = 1'b0;
      chk("t6_cnt", 32'(done_cnt), i);
    end
    @(negedge clk);
    #1;
    chk("t6_wrap", 32'(done_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
